// File: rtl/intel_vip_reset_request_ctrl.sv
// Reset request controller: guaranteed-width reset pulse plus a done handshake.
// Optional WAIT_DONE timeout/retry enabled by defining INTEL_VIP_RESET_REQ_TIMEOUT_EN.
module intel_vip_reset_request_ctrl #(
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic req_in,
    input  logic done_in,
    output logic reset_out,
    output logic busy_out,
    output logic ack_out,
    output logic timeout_out
);
    localparam int MAX_PH = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_ALL = (MAX_PH > TIMEOUT_CYCLES) ? MAX_PH : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        WAIT_DONE = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             seen_low_q, seen_low_d;
    logic             reset_q, reset_d;
    logic             ack_q, ack_d;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        reset_d    = 1'b0;
        ack_d      = 1'b0;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                seen_low_d = 1'b0;
                if (req_in) begin
                    state_d = ASSERT;
                    reset_d = 1'b1;
                end
            end
            ASSERT: begin
                seen_low_d = seen_low_q | ~done_in;
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else begin
                    reset_d = 1'b1;
                    cnt_d   = cnt_inc;
                end
            end
            WAIT_DONE: begin
                // A done seen only while still high from before the pulse must not complete.
                seen_low_d = seen_low_q | ~done_in;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (done_in && seen_low_q) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d    = ASSERT;
                    cnt_d      = '0;
                    seen_low_d = 1'b0;
                    reset_d    = 1'b1;
                    timeout_d  = 1'b1;
                end
`endif
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d    = ASSERT;
                cnt_d      = '0;
                seen_low_d = 1'b0;
                reset_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ASSERT;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
            reset_q    <= 1'b1;
            ack_q      <= 1'b0;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            reset_q    <= reset_d;
            ack_q      <= ack_d;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign reset_out = reset_q;
    assign busy_out  = (state_q != IDLE);
    assign ack_out   = ack_q;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_intel_vip_reset_request_ctrl.sv
// Bench for intel_vip_reset_request_ctrl: directed phases plus random traffic against a countdown model.
module tb_intel_vip_reset_request_ctrl;
    localparam int P = 16;
    localparam int H = 4;
    localparam int T = 32;

    logic clk_in = 1'b0;
    logic reset_n_in, req_in, done_in;
    logic reset_out, busy_out, ack_out, timeout_out;

    intel_vip_reset_request_ctrl #(
        .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .req_in(req_in), .done_in(done_in),
        .reset_out(reset_out), .busy_out(busy_out), .ack_out(ack_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining pulse cycles, waiting flag, remaining holdoff cycles.
    int pulse_left, wait_cnt, hold_left;
    bit waiting, seen0;
    bit m_reset, m_busy, m_ack, m_to;
    int dut_acks, dut_tos, mdl_acks, mdl_tos;

    task automatic model_outputs();
        m_reset = (pulse_left > 0);
        m_busy  = (pulse_left > 0) || waiting || (hold_left > 0);
    endtask

    task automatic model_reset();
        pulse_left = P; wait_cnt = 0; hold_left = 0;
        waiting = 0; seen0 = 0; m_ack = 0; m_to = 0;
        model_outputs();
    endtask

    task automatic model_step(input bit r, input bit d);
        m_ack = 0; m_to = 0;
        if (pulse_left > 0) begin
            if (!d) seen0 = 1;
            pulse_left--;
            if (pulse_left == 0) begin waiting = 1; wait_cnt = 0; end
        end else if (waiting) begin
            if (d && seen0) begin
                waiting = 0; m_ack = 1; hold_left = H;
            end else begin
                if (!d) seen0 = 1;
                wait_cnt++;
`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
                if (wait_cnt == T) begin
                    waiting = 0; m_to = 1; pulse_left = P; seen0 = 0;
                end
`endif
            end
        end else if (hold_left > 0) begin
            hold_left--;
        end else if (r) begin
            pulse_left = P; seen0 = 0;
        end
        model_outputs();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".reset_out"},   reset_out,   m_reset);
        chk({tag, ".busy_out"},    busy_out,    m_busy);
        chk({tag, ".ack_out"},     ack_out,     m_ack);
        chk({tag, ".timeout_out"}, timeout_out, m_to);
        if (ack_out === 1'b1) dut_acks++;
        if (timeout_out === 1'b1) dut_tos++;
        if (m_ack) mdl_acks++;
        if (m_to) mdl_tos++;
    endtask

    // Called at a negedge: drive, let one active edge pass, check at the next negedge.
    task automatic step(input string tag, input bit r, input bit d);
        req_in = r; done_in = d;
        @(posedge clk_in);
        model_step(r, d);
        @(negedge clk_in);
        check_all(tag);
    endtask

    task automatic apply_reset(input int ncyc);
        reset_n_in = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (ncyc) begin
            @(posedge clk_in);
            model_reset();
            @(negedge clk_in);
            check_all("rst_hold");
        end
        reset_n_in = 1'b1;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 300 && m_busy; i++) step("drain", 1'b0, i[0]);
        chk("idle_reached", busy_out, 1'b0);
    endtask

    task automatic clear_counts();
        dut_acks = 0; dut_tos = 0; mdl_acks = 0; mdl_tos = 0;
    endtask

    initial begin
        bit d;
        reset_n_in = 1'b0; req_in = 1'b0; done_in = 1'b0;
        model_reset();
        clear_counts();
        @(negedge clk_in);
        apply_reset(3);

        // Power-on: done low through the pulse, rises 5 cycles after reset_out falls.
        clear_counts();
        repeat (P) step("poweron_pulse", 1'b0, 1'b0);
        chk("poweron_reset_fell", reset_out, 1'b0);
        repeat (5) step("poweron_wait", 1'b0, 1'b0);
        repeat (8) step("poweron_done", 1'b0, 1'b1);
        chk_int("poweron_ack_count", dut_acks, 1);
        chk("poweron_idle", busy_out, 1'b0);

        // Stale done: high through the pulse and 3 cycles after, low 2, then high.
        clear_counts();
        step("stale_req", 1'b1, 1'b1);
        repeat (P + 3) step("stale_hi", 1'b0, 1'b1);
        chk_int("stale_no_early_ack", dut_acks, 0);
        repeat (2) step("stale_lo", 1'b0, 1'b0);
        repeat (10) step("stale_final", 1'b0, 1'b1);
        chk_int("stale_ack_count", dut_acks, 1);

        // Held request with random done.
        go_idle();
        clear_counts();
        for (int i = 0; i < 100; i++) step("held", 1'b1, ($urandom_range(0, 9) < 6));
        chk_int("held_ack_count", dut_acks, mdl_acks);

        // Mid-sequence asynchronous reset at count 7 of the pulse.
        go_idle();
        step("mid_req", 1'b1, 1'b0);
        repeat (7) step("mid_pulse", 1'b0, 1'b0);
        apply_reset(3);
        repeat (P) step("mid_full_pulse", 1'b0, 1'b0);
        chk("mid_pulse_end", reset_out, 1'b0);

        // Done held low in WAIT_DONE for a long stretch.
        go_idle();
        clear_counts();
        step("tmo_req", 1'b1, 1'b0);
        repeat (200) step("tmo_wait", 1'b0, 1'b0);
        chk_int("tmo_count", dut_tos, mdl_tos);

`ifdef INTEL_VIP_RESET_REQ_TIMEOUT_EN
        // Completion on the expiry cycle must win.
        repeat (4) step("race_flush", 1'b0, 1'b1);
        go_idle();
        step("race_req", 1'b1, 1'b0);
        repeat (P) step("race_pulse", 1'b0, 1'b0);
        repeat (T - 1) step("race_wait", 1'b0, 1'b0);
        step("race_edge", 1'b0, 1'b1);
        chk("race_ack", ack_out, 1'b1);
        chk("race_no_timeout", timeout_out, 1'b0);
`endif

        // Random traffic with occasional resets.
        clear_counts();
        d = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) d = ~d;
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 3));
            else step("rand", ($urandom_range(0, 9) == 0), d);
        end
        chk_int("rand_ack_count", dut_acks, mdl_acks);
        chk_int("rand_tmo_count", dut_tos, mdl_tos);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
